// File: rtl/conv_wb_buffer.sv
// conv_wb_buffer: write-back FIFO between conv2d and the shared image memory.
// Result writes from conv2d are queued, then drained one entry per granted
// cycle through a req/gnt port. Committed pixels are counted so that a single
// frame_done pulse marks the landing of the last pixel of an IMG_W x IMG_H frame.
module conv_wb_buffer #(
    parameter int IMG_W = 50,
    parameter int IMG_H = 50,
    parameter int AW    = 17,
    parameter int DW    = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_we,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic                     overflow,
    output logic                     addr_err
);

    localparam int PIX = IMG_W * IMG_H;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int CW  = $clog2(PIX + 1);

    localparam logic [AW-1:0] PIX_A      = AW'(PIX);
    localparam logic [CW-1:0] PIX_C      = CW'(PIX);
    localparam logic [CW-1:0] PIX_LAST_C = CW'(PIX - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr,
    // so it carries no reset.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          in_range;
    logic          push_ok;
    logic          full;
    logic          pop;
    logic          push_acc;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    // Push/pop qualification. A full FIFO still accepts a push when the head
    // leaves in the same cycle; start flushes first, so its push always fits.
    always_comb begin
        in_range = in_addr < PIX_A;
        push_ok  = in_we & in_range;
        full     = (level == DEPTH_L);
        pop      = mem_req & mem_gnt;
        push_acc = push_ok & (~full | pop);
        wr_en    = start ? push_ok : push_acc;
        wr_idx   = start ? '0 : wr_ptr;
    end

    // Memory-side view of the head entry; held at zero while empty so the
    // port is quiet after reset or flush.
    always_comb begin
        mem_req  = (level != '0);
        mem_we   = pop;
        mem_addr = mem_req ? addr_mem[rd_ptr] : '0;
        mem_data = mem_req ? data_mem[rd_ptr] : '0;
    end

    // Entry write at the tail (slot 0 when the same cycle flushes).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[wr_idx] <= in_addr;
            data_mem[wr_idx] <= in_data;
        end
    end

    // Pointers, occupancy, commit counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            addr_err   <= 1'b0;
        end else if (start) begin
            rd_ptr     <= '0;
            wr_ptr     <= push_ok ? PW'(1) : '0;
            level      <= push_ok ? LW'(1) : '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            addr_err   <= in_we & ~in_range;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_acc, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // The counter saturates at a full frame, so later commits never
            // produce a second pulse.
            if (pop && (count != PIX_C)) begin
                count <= count + CW'(1);
            end
            frame_done <= pop && (count == PIX_LAST_C);
            if (push_ok && !push_acc) begin
                overflow <= 1'b1;
            end
            if (in_we && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_wb_buffer.sv
// Bench for conv_wb_buffer: randomized and directed write streams against a
// queue-based model; a negedge monitor scoreboards every memory commit.
module tb_conv_wb_buffer;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int TOTAL = 2500;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_we = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          mem_gnt = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [3:0]    level;
    logic          frame_done;
    logic          overflow;
    logic          addr_err;

    conv_wb_buffer #(
        .IMG_W(50), .IMG_H(50), .AW(AW), .DW(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .level(level),
        .frame_done(frame_done), .overflow(overflow), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    ent_t          mfifo[$];
    bit            ov_m = 1'b0;
    bit            ae_m = 1'b0;
    bit            exp_we = 1'b0;
    bit            fd_pending = 1'b0;
    int            commits = 0;
    int            fd_seen = 0;
    logic [DW-1:0] golden [TOTAL];
    logic [DW-1:0] img    [TOTAL];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: check the state left by the previous edge, then apply
    // this cycle's inputs and advance the model for the coming edge.
    task automatic cyc(input bit r, input bit s, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit g);
        int size0;
        bit ok;
        @(posedge clk);
        #1;
        size0 = mfifo.size();
        chk("level", 64'(level), 64'(size0));
        chk("mem_req", 64'(mem_req), 64'(size0 != 0));
        chk("overflow", 64'(overflow), 64'(ov_m));
        chk("addr_err", 64'(addr_err), 64'(ae_m));
        if (size0 > 0) begin
            chk("head_addr", 64'(mem_addr), 64'(mfifo[0].a));
            chk("head_data", 64'(mem_data), 64'(mfifo[0].d));
        end
        if (r || s) g = 1'b0;
        rst = r; start = s; in_we = we; in_addr = a; in_data = d; mem_gnt = g;
        exp_we = (size0 > 0) && g;
        ok = we && (a < TOTAL);
        if (r) begin
            mfifo.delete();
            ov_m = 1'b0;
            ae_m = 1'b0;
        end else if (s) begin
            mfifo.delete();
            ov_m = 1'b0;
            ae_m = we && !ok;
            if (ok) mfifo.push_back('{a, d});
        end else begin
            if (ok) begin
                if (size0 < DEPTH || exp_we) mfifo.push_back('{a, d});
                else ov_m = 1'b1;
            end
            if (we && !ok) ae_m = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, g);
    endtask

    task automatic drain(input bit random_gnt);
        int n = 0;
        while (mfifo.size() > 0 && n < 2000) begin
            cyc(0, 0, 0, '0, '0, random_gnt ? bit'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        tests++;
        if (mfifo.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d entries left, required 0", mfifo.size());
        end
        idle(2, 1'b0);
    endtask

    task automatic post_rst_chk();
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_data", 64'(mem_data), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
    endtask

    // Commit monitor: every mem_we must match the model's expectation and pop
    // the oldest model entry; frame_done follows the 2500th commit by one edge.
    always @(negedge clk) begin
        ent_t e;
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("frame_done", 64'(frame_done), 64'(fd_pending));
        if (frame_done) fd_seen++;
        fd_pending = 1'b0;
        if (mem_we && exp_we) begin
            if (mfifo.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: commit seen with no entry expected");
            end else begin
                e = mfifo.pop_front();
                chk("commit_addr", 64'(mem_addr), 64'(e.a));
                chk("commit_data", 64'(mem_data), 64'(e.d));
                if (e.a < TOTAL) img[e.a] = mem_data;
                if (!(rst || start) && commits < TOTAL) begin
                    commits++;
                    if (commits == TOTAL) fd_pending = 1'b1;
                end
            end
        end
        if (rst || start) commits = 0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int guard;
        bit g;
        for (int i = 0; i < TOTAL; i++) golden[i] = DW'($urandom_range(0, 4095));

        // Reset and initial state
        cyc(1, 0, 0, '0, '0, 0);
        cyc(0, 0, 0, '0, '0, 0);
        post_rst_chk();

        // T1: three pushes with grant held high
        cyc(0, 0, 1, 17'd0, 12'h0AA, 1);
        cyc(0, 0, 1, 17'd1, 12'h0BB, 1);
        cyc(0, 0, 1, 17'd2, 12'h0CC, 1);
        idle(4, 1'b1);

        // T2: fill with grant low, ninth push dropped
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, AW'(10 + i), DW'($urandom_range(0, 4095)), 0);
        idle(2, 1'b0);
        drain(1'b0);

        // T3: full FIFO, push and grant together
        cyc(0, 1, 0, '0, '0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, AW'(20 + i), DW'($urandom_range(0, 4095)), 0);
        cyc(0, 0, 1, 17'd28, 12'h123, 1);
        idle(2, 1'b0);
        drain(1'b1);

        // T4: out-of-range address
        cyc(0, 0, 1, 17'd2500, 12'h055, 0);
        cyc(0, 0, 1, 17'd131071, 12'h066, 1);
        idle(2, 1'b1);

        // T5: full frame, grant randomly withheld
        for (int i = 0; i < TOTAL; i++) img[i] = 'x;
        fd_seen = 0;
        cyc(0, 1, 0, '0, '0, 0);
        nxt = 0;
        guard = 0;
        while (nxt < TOTAL && guard < 40000) begin
            guard++;
            g = bit'($urandom_range(0, 1));
            if (mfifo.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
                cyc(0, 0, 1, AW'(nxt), golden[nxt], g);
                nxt++;
            end else begin
                cyc(0, 0, 0, '0, '0, g);
            end
        end
        drain(1'b1);
        chk("t5_pushed", 64'(nxt), 64'(TOTAL));
        chk("t5_commits", 64'(commits), 64'(TOTAL));
        chk("t5_frame_done_count", 64'(fd_seen), 64'(1));
        chk("t5_overflow", 64'(overflow), 64'(0));
        for (int i = 0; i < TOTAL; i++) chk("t5_pixel", 64'(img[i]), 64'(golden[i]));

        // Extra commits after a completed frame must not re-pulse
        cyc(0, 0, 1, 17'd3, 12'h777, 1);
        cyc(0, 0, 1, 17'd4, 12'h778, 1);
        drain(1'b0);
        chk("t5_no_repulse", 64'(fd_seen), 64'(1));

        // T6: reset with entries pending, then start with a push
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, AW'(100 + i), DW'($urandom_range(0, 4095)), 0);
        cyc(1, 0, 0, '0, '0, 0);
        cyc(0, 0, 0, '0, '0, 0);
        post_rst_chk();
        cyc(0, 1, 1, 17'd7, 12'h3C3, 0);
        cyc(0, 0, 0, '0, '0, 0);
        chk("t6_level_after_start", 64'(level), 64'(1));
        drain(1'b0);
        chk("t6_commits_restart", 64'(commits), 64'(1));
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
